// File: rtl/riscv_mem_arbiter.sv
// Fetch/data arbiter in front of the unified memory bus.
// One transaction in flight, data port wins ties, per-port timeout.
module riscv_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                mem_req,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                owner
);

    localparam int MW = DATA_W / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam bit TO_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic          grant_d;
    logic          grant_i;
    logic          done;
    logic          tmo;
    logic          cnt_hit;

    assign cnt_hit = TO_EN && (cnt == CNT_LAST);
    assign mem_req = (state == REQ);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        done     = 1'b0;
        tmo      = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_req) begin
                    grant_d  = 1'b1;
                    state_nx = REQ;
                end else if (i_req) begin
                    grant_i  = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (mem_ready && mem_rvalid) begin
                    done = 1'b1;
                end else if (cnt_hit) begin
                    tmo = 1'b1;
                end else if (mem_ready) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    done = 1'b1;
                end else if (cnt_hit) begin
                    tmo = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (done || tmo) begin
            state_nx = IDLE;
        end
    end

    // request latch, timeout counter and registered responses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner     <= 1'b0;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            i_rvalid  <= 1'b0;
            i_rdata   <= '0;
            i_err     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (grant_d) begin
                owner     <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_wmask <= d_wmask;
            end else if (grant_i) begin
                owner     <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= i_addr;
                mem_wdata <= '0;
                mem_wmask <= MW'(0);
            end
            if (grant_d || grant_i) begin
                cnt <= '0;
            end else if (state != IDLE && cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            if (done || tmo) begin
                if (owner) begin
                    d_rvalid <= 1'b1;
                    d_err    <= tmo;
                    d_rdata  <= (done && !mem_we) ? mem_rdata : '0;
                end else begin
                    i_rvalid <= 1'b1;
                    i_err    <= tmo;
                    i_rdata  <= done ? mem_rdata : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Random bench for riscv_mem_arbiter against a
// transaction-level model of grant, latency and timeout.
module tb_riscv_mem_arbiter;

    localparam int TO  = 8;
    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wmask = '0;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;
    logic        owner;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wmask   (d_wmask),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    int total = 0;
    int bad   = 0;
    int k     = 0;

    // model of the transaction in flight (cycle numbers)
    bit          have = 1'b0;
    int          g, rdy_c, cmp_c, tmo_c, end_c;
    logic [31:0] m_rd;
    bit          allow_new = 1'b0;
    bit          force_en = 1'b0;
    int          force_r, force_v;

    // expected held outputs
    logic        e_owner, e_we, e_i_err, e_d_err;
    logic [31:0] e_addr, e_wdata, e_i_rdata, e_d_rdata;
    logic [3:0]  e_wmask;

    task automatic check(string tag, logic [63:0] got,
                         logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h cycle %0d",
                     tag, got, exp, k);
        end
    endtask

    task automatic clear_model();
        have      = 1'b0;
        e_owner   = 1'b0;
        e_we      = 1'b0;
        e_addr    = '0;
        e_wdata   = '0;
        e_wmask   = '0;
        e_i_rdata = '0;
        e_i_err   = 1'b0;
        e_d_rdata = '0;
        e_d_err   = 1'b0;
    endtask

    task automatic new_d();
        d_req   = 1'b1;
        d_we    = 1'($urandom);
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_wmask = 4'($urandom);
    endtask

    task automatic new_i();
        i_req  = 1'b1;
        i_addr = $urandom;
    endtask

    task automatic step();
        bit idle_now;
        bit rv_i;
        bit rv_d;
        bit err;
        int req_end;
        int r;
        int v;
        idle_now = !have || k > end_c;
        req_end  = (rdy_c < tmo_c) ? rdy_c : tmo_c;
        check("busy", 64'(busy), 64'(have && k > g && k <= end_c));
        check("mem_req", 64'(mem_req),
              64'(have && k > g && k <= req_end));
        check("owner", 64'(owner), 64'(e_owner));
        check("mem_we", 64'(mem_we), 64'(e_we));
        check("mem_addr", 64'(mem_addr), 64'(e_addr));
        check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
        check("mem_wmask", 64'(mem_wmask), 64'(e_wmask));
        rv_i = have && k == end_c + 1 && !e_owner;
        rv_d = have && k == end_c + 1 && e_owner;
        err  = cmp_c > tmo_c;
        if (rv_i) begin
            e_i_err   = err;
            e_i_rdata = err ? 32'h0 : m_rd;
        end
        if (rv_d) begin
            e_d_err   = err;
            e_d_rdata = (err || e_we) ? 32'h0 : m_rd;
        end
        check("i_rvalid", 64'(i_rvalid), 64'(rv_i));
        check("d_rvalid", 64'(d_rvalid), 64'(rv_d));
        check("i_rdata", 64'(i_rdata), 64'(e_i_rdata));
        check("i_err", 64'(i_err), 64'(e_i_err));
        check("d_rdata", 64'(d_rdata), 64'(e_d_rdata));
        check("d_err", 64'(d_err), 64'(e_d_err));

        // requesters react to what they see this cycle
        if (d_req && d_rvalid) begin
            if (allow_new && $urandom % 4 != 0) new_d();
            else d_req = 1'b0;
        end else if (allow_new) begin
            if (!d_req && $urandom % 3 == 0) new_d();
            else if (d_req && $urandom % 40 == 0) d_req = 1'b0;
        end
        if (i_req && i_rvalid) begin
            if (allow_new && $urandom % 4 != 0) new_i();
            else i_req = 1'b0;
        end else if (allow_new) begin
            if (!i_req && $urandom % 3 == 0) new_i();
            else if (i_req && $urandom % 40 == 0) i_req = 1'b0;
        end

        // grant: D wins, only when the arbiter is idle
        if (idle_now && (d_req || i_req)) begin
            have = 1'b1;
            g    = k;
            if (d_req) begin
                e_owner = 1'b1;
                e_we    = d_we;
                e_addr  = d_addr;
                e_wdata = d_wdata;
                e_wmask = d_wmask;
            end else begin
                e_owner = 1'b0;
                e_we    = 1'b0;
                e_addr  = i_addr;
                e_wdata = '0;
                e_wmask = '0;
            end
            m_rd = $urandom;
            if (force_en) begin
                r = force_r;
                v = force_v;
            end else begin
                r = $urandom_range(0, 6);
                v = ($urandom % 5 == 0) ? -1 : $urandom_range(0, 3);
            end
            rdy_c = g + 1 + r;
            tmo_c = g + TO;
            cmp_c = (v < 0) ? BIG : rdy_c + v;
            end_c = (cmp_c <= tmo_c) ? cmp_c : tmo_c;
        end

        mem_ready  = have && k == rdy_c && k <= tmo_c;
        mem_rvalid = (have && k == cmp_c && cmp_c <= tmo_c) ||
                     (idle_now && $urandom % 4 == 0);
        mem_rdata  = (have && k == cmp_c) ? m_rd : $urandom;
        @(posedge clk);
        #1;
        k++;
    endtask

    initial begin
        clear_model();
        i_req = 1'b1;
        d_req = 1'b1;
        i_addr = 32'h8000_0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_owner", 64'(owner), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_i_rvalid", 64'(i_rvalid), 64'(0));
        check("rst_d_rvalid", 64'(d_rvalid), 64'(0));
        i_req = 1'b0;
        d_req = 1'b0;
        rst   = 1'b1;
        k     = 0;

        allow_new = 1'b1;
        repeat (1500) step();
        allow_new = 1'b0;
        d_req = 1'b0;
        i_req = 1'b0;
        repeat (20) step();

        // fetch stuck in RESP, then reset mid-transaction
        force_en = 1'b1;
        force_r  = 0;
        force_v  = -1;
        i_req    = 1'b1;
        i_addr   = 32'h8000_0000;
        repeat (3) step();
        check("pre_rst_busy", 64'(busy), 64'(1));
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_mem_req", 64'(mem_req), 64'(0));
        check("mid_rst_mem_addr", 64'(mem_addr), 64'(0));
        check("mid_rst_i_rvalid", 64'(i_rvalid), 64'(0));
        i_req = 1'b0;
        @(posedge clk);
        #1;
        check("held_rst_i_rvalid", 64'(i_rvalid), 64'(0));
        check("held_rst_d_rvalid", 64'(d_rvalid), 64'(0));
        rst      = 1'b1;
        force_en = 1'b0;
        clear_model();
        k += 2;

        allow_new = 1'b1;
        repeat (600) step();
        allow_new = 1'b0;
        d_req = 1'b0;
        i_req = 1'b0;
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
